fifo_uart_tx: RTL
=================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, clock frequency in Hz.
REQ-002 Parameter BIT_RATE, default 115200, serial bit rate in bit/s.
REQ-003 Parameter PAYLOAD_BITS, default 8, data bits per frame.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 enable  input  1  permits starting a new frame when high.
REQ-008 fifo_empty  input  1  upstream FIFO empty flag.
REQ-009 fifo_read_data  input  PAYLOAD_BITS  upstream FIFO head word; valid whenever fifo_empty is low.
REQ-010 fifo_read  output  1  one-cycle pop request to the upstream FIFO; registered.
REQ-011 tx  output  1  serial line, idle high; registered.
REQ-012 busy  output  1  high while a frame is in progress; registered.

Function
REQ-013 CYCLES_PER_BIT SHALL be CLK_FREQ/BIT_RATE with integer truncation; values below 2 are illegal configurations.
REQ-014 Baud counter width SHALL be $clog2(CYCLES_PER_BIT); bit counter SHALL count 0..PAYLOAD_BITS-1 with no overflow.
REQ-015 States SHALL be IDLE, START, DATA, STOP.
REQ-016 IDLE: on an edge where enable=1 and fifo_empty=0, the block SHALL capture fifo_read_data into the shift register, set fifo_read=1, tx=0, busy=1 and enter START.
REQ-017 fifo_read SHALL be high for exactly one cycle per frame (the first START cycle) and SHALL never be asserted outside that cycle.
REQ-018 fifo_empty SHALL be sampled only in IDLE; the popped word SHALL never be re-read or read twice.
REQ-019 START: tx=0 for exactly CYCLES_PER_BIT cycles, then enter DATA.
REQ-020 DATA: data bits SHALL be sent LSB first, each for exactly CYCLES_PER_BIT cycles; after bit PAYLOAD_BITS-1 enter STOP.
REQ-021 STOP: tx=1 for exactly STOP_BITS*CYCLES_PER_BIT cycles, then enter IDLE with busy=0.
REQ-022 Total frame length SHALL be (1+PAYLOAD_BITS+STOP_BITS)*CYCLES_PER_BIT cycles, measured from the first START cycle.
REQ-023 Back-to-back: if enable=1 and fifo_empty=0 on the first IDLE cycle after STOP, the next START SHALL begin on the following cycle (one idle-high cycle between frames, no more).
REQ-024 Deasserting enable mid-frame SHALL NOT abort the frame; it only blocks the next start.
REQ-025 fifo_read_data changes after capture SHALL NOT affect the frame in progress.

Reset
REQ-026 On reset=1 at an edge: state=IDLE, tx=1, fifo_read=0, busy=0, baud and bit counters=0, shift register=0.
REQ-027 Reset mid-frame SHALL abort it; tx=1 from the next cycle; the already-popped word is discarded, not re-popped.
REQ-028 Reset SHALL take priority over every other condition, including a start condition on the same edge.

Verification (CLK_FREQ=100, BIT_RATE=10, so CYCLES_PER_BIT=10; PAYLOAD_BITS=8, STOP_BITS=1)
REQ-029 FIFO holds 0xA5, enable=1 -> one fifo_read pulse; tx = 0,1,0,1,0,0,1,0,1,1 each held 10 cycles; busy high 100 cycles.
REQ-030 FIFO holds 0x00 then 0xFF -> exactly 2 fifo_read pulses 101 cycles apart; one idle cycle between frames; total 201 cycles.
REQ-031 fifo_empty=1 for 500 cycles -> fifo_read never asserted, tx=1, busy=0 throughout.
REQ-032 FIFO holds 3 words, enable=0 -> no activity; enable pulsed high 1 cycle -> exactly one frame, then idle with 2 words left.
REQ-033 Reset asserted at frame cycle 35 for 1 cycle -> tx=1 and busy=0 next cycle; next frame starts with the following FIFO word.
REQ-034 STOP_BITS=2, byte 0x3C -> stop level held 20 cycles; frame 110 cycles.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from an upstream FIFO and serialises them LSB first.
// Frame: start bit, PAYLOAD_BITS data bits, STOP_BITS stop bits; each bit is CLK_FREQ/BIT_RATE cycles.
module fifo_uart_tx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    fifo_empty,
  input  logic [PAYLOAD_BITS-1:0] fifo_read_data,
  output logic                    fifo_read,
  output logic                    tx,
  output logic                    busy
);

  localparam int CYCLES_PER_BIT = CLK_FREQ / BIT_RATE;
  localparam int BAUD_W = (CYCLES_PER_BIT > 2) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int BIT_W  = (PAYLOAD_BITS > 2) ? $clog2(PAYLOAD_BITS) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CYCLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    fifo_read_q, fifo_read_d;
  logic                    baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    fifo_read_d = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        baud_d = '0;
        bit_d  = '0;
        // The pop is issued together with the capture, so the word is consumed exactly once.
        if (enable && !fifo_empty) begin
          shift_d     = fifo_read_data;
          fifo_read_d = 1'b1;
          tx_d        = 1'b0;
          busy_d      = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        // The bit counter is reused to count stop bits.
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      fifo_read_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      fifo_read_q <= fifo_read_d;
    end
  end

  assign fifo_read = fifo_read_q;
  assign tx        = tx_q;
  assign busy      = busy_q;

endmodule
